// File: rtl/fpu_operand_pair_rt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fpu_operand_pair_rt: pairs a word stream into tagged A/B operand pairs.|
// | Optional feature macro: FPU_PAIR_FLUSH_EN (adds the flush input).      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fpu_operand_pair_rt #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_rdy,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [TAGW-1:0]  out_tag,
   input  logic             out_rdy
`ifdef FPU_PAIR_FLUSH_EN
   ,
   input  logic             flush
`endif
);

`ifndef FPU_PAIR_FLUSH_EN
   logic flush;
   assign flush = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_HALF   = 2'd1,
      S_PAIR   = 2'd2,
      S_PAIR_A = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] nxt_q, nxt_d;
   logic [TAGW-1:0]  tag_q, tag_d;
   logic             acc;
   logic             hs;

   // in_rdy depends on state, flush and rst only, never on in_vld/in_data.
   assign in_rdy  = !rst && !flush && (state_q != S_PAIR_A);
   assign out_vld = (state_q == S_PAIR) || (state_q == S_PAIR_A);
   assign out_a   = a_q;
   assign out_b   = b_q;
   assign out_tag = tag_q;
   assign acc     = in_vld && in_rdy;
   assign hs      = out_vld && out_rdy;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      nxt_d   = nxt_q;
      tag_d   = hs ? tag_q + {{(TAGW-1){1'b0}}, 1'b1} : tag_q;
      case (state_q)
         S_EMPTY: begin
            if (acc) begin
               a_d     = in_data;
               state_d = S_HALF;
            end
         end
         S_HALF: begin
            if (flush) begin
               state_d = S_EMPTY;
            end else if (acc) begin
               b_d     = in_data;
               state_d = S_PAIR;
            end
         end
         S_PAIR: begin
            if (hs && acc) begin
               a_d     = in_data;
               state_d = S_HALF;
            end else if (hs) begin
               state_d = S_EMPTY;
            end else if (acc) begin
               nxt_d   = in_data;
               state_d = S_PAIR_A;
            end
         end
         S_PAIR_A: begin
            // A flush drops only the staged A; the held pair survives.
            if (hs && flush) begin
               state_d = S_EMPTY;
            end else if (hs) begin
               a_d     = nxt_q;
               state_d = S_HALF;
            end else if (flush) begin
               state_d = S_PAIR;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         nxt_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         nxt_q   <= nxt_d;
         tag_q   <= tag_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpu_operand_pair_rt.sv
`default_nettype none
// Bench for fpu_operand_pair_rt: word-queue model checked every cycle, plus literal pair logs.
module tb_fpu_operand_pair_rt;
   localparam int WIDTH = 32;
   localparam int TAGW  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_vld = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_rdy;
   logic             out_vld;
   logic [WIDTH-1:0] out_a, out_b;
   logic [TAGW-1:0]  out_tag;
   logic             out_rdy = 1'b0;
   logic             flush_tb = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   fpu_operand_pair_rt #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
      .out_vld(out_vld), .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
      .out_rdy(out_rdy)
`ifdef FPU_PAIR_FLUSH_EN
      , .flush(flush_tb)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the unconsumed words, in arrival order, and the count of consumed pairs.
   logic [WIDTH-1:0] wq[$];
   int unsigned      cons = 0;

   always @(posedge clk) begin
      if (rst) begin
         wq.delete();
         cons = 0;
      end else begin
         if (wq.size() >= 2 && out_rdy) begin
            void'(wq.pop_front());
            void'(wq.pop_front());
            cons++;
         end
         if (in_vld) wq.push_back(in_data);
         if (flush_tb) while (wq.size() % 2 != 0) void'(wq.pop_back());
      end
   end

   // Compare process plus a log of observed handshakes.
   logic [WIDTH-1:0] log_a[$], log_b[$];
   logic [TAGW-1:0]  log_t[$];
   bit               rdy_dropped = 1'b0;

   always @(negedge clk) begin
      chk("in_rdy", {31'b0, in_rdy},
          {31'b0, (!rst && !flush_tb && wq.size() < 3)});
      if (!rst) begin
         chk("out_vld", {31'b0, out_vld}, {31'b0, (wq.size() >= 2)});
         if (wq.size() >= 2) begin
            chk("out_a", out_a, wq[0]);
            chk("out_b", out_b, wq[1]);
            chk("out_tag", {28'b0, out_tag}, {28'b0, 4'(cons)});
         end
         if (out_vld && out_rdy) begin
            log_a.push_back(out_a);
            log_b.push_back(out_b);
            log_t.push_back(out_tag);
         end
         if (!in_rdy) rdy_dropped = 1'b1;
      end
   end

   task automatic clr_log();
      log_a.delete(); log_b.delete(); log_t.delete();
      rdy_dropped = 1'b0;
   endtask

   task automatic chk_pair(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [TAGW-1:0] t);
      if (idx >= log_a.size()) begin
         n_checks++; n_fail++;
         $display("FAIL pair_log[%0d]: got %0d pairs expected at least %0d", idx, log_a.size(), idx + 1);
      end else begin
         chk($sformatf("pair%0d_a", idx), log_a[idx], a);
         chk($sformatf("pair%0d_b", idx), log_b[idx], b);
         chk($sformatf("pair%0d_tag", idx), {28'b0, log_t[idx]}, {28'b0, t});
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] w);
      int n = 0;
      while (!in_rdy && n < 50) begin
         in_vld = 1'b0;
         cyc(1);
         n++;
      end
      if (n >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: in_rdy stayed 0, expected 1 within 50 cycles");
      end
      in_vld  = 1'b1;
      in_data = w;
      cyc(1);
      in_vld  = 1'b0;
   endtask

   task automatic do_reset();
      in_vld = 1'b0; out_rdy = 1'b0; flush_tb = 1'b0; rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      clr_log();
   endtask

   initial begin
      cyc(1);
      do_reset();
      @(negedge clk);
      chk("rst_out_vld", {31'b0, out_vld}, 32'h0);
      chk("rst_out_a", out_a, 32'h0);
      chk("rst_out_b", out_b, 32'h0);
      chk("rst_out_tag", {28'b0, out_tag}, 32'h0);
      chk("rst_in_rdy", {31'b0, in_rdy}, 32'h1);
      @(posedge clk); #1;

      // Single pair
      out_rdy = 1'b1;
      send(32'h11); send(32'h22);
      cyc(3);
      chk("single_count", log_a.size(), 1);
      chk_pair(0, 32'h11, 32'h22, 4'd0);

      // Full-throughput stream
      do_reset();
      out_rdy = 1'b1;
      for (int i = 1; i <= 8; i++) send(i);
      cyc(3);
      for (int k = 0; k < 4; k++) chk_pair(k, 2*k + 1, 2*k + 2, 4'(k));
      chk("stream_rdy_never_low", {31'b0, rdy_dropped}, 32'h0);

      // Backpressure: one extra word absorbed, then in_rdy falls
      do_reset();
      out_rdy = 1'b0;
      send(32'h41); send(32'h42); send(32'h33);
      @(negedge clk);
      chk("bp_in_rdy_low", {31'b0, in_rdy}, 32'h0);
      chk("bp_hold_a", out_a, 32'h41);
      cyc(3);
      out_rdy = 1'b1;
      send(32'h34);
      cyc(3);
      chk_pair(0, 32'h41, 32'h42, 4'd0);
      chk_pair(1, 32'h33, 32'h34, 4'd1);

      // Tag wrap over 17 pairs
      do_reset();
      out_rdy = 1'b1;
      for (int i = 0; i < 34; i++) send(32'h100 + i);
      cyc(3);
      chk("wrap_count", log_a.size(), 17);
      chk_pair(15, 32'h11e, 32'h11f, 4'd15);
      chk_pair(16, 32'h120, 32'h121, 4'd0);

`ifdef FPU_PAIR_FLUSH_EN
      // Flush drops a partial operand
      do_reset();
      out_rdy = 1'b1;
      send(32'hAA);
      flush_tb = 1'b1; cyc(1); flush_tb = 1'b0;
      send(32'hBB); send(32'hCC);
      cyc(3);
      chk("flush_count", log_a.size(), 1);
      chk_pair(0, 32'hBB, 32'hCC, 4'd0);
`endif

      // Reset while in S_PAIR_A
      do_reset();
      out_rdy = 1'b0;
      send(32'h1); send(32'h2); send(32'h3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_out_vld", {31'b0, out_vld}, 32'h0);
      chk("rstmid_tag", {28'b0, out_tag}, 32'h0);
      chk("rstmid_in_rdy", {31'b0, in_rdy}, 32'h1);
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/fpu_operand_pair_rt.md
# fpu_operand_pair_rt

Downstream consumer of the FPU input flip buffer: takes the single-word stream that buffer emits (`do_`/`d_out`) and assembles consecutive words into operand pairs (A then B) for a two-operand FPU operation. It presents each complete pair with a wrapping sequence tag to the FPU issue logic under a valid/ready handshake. Its `in_rdy` drives the buffer's `dout_en`, so backpressure propagates upstream and raises the buffer's `pause`.

## Interface
- `WIDTH`, 32, operand word width; matches the flip buffer's `WIDTH`.
- `TAGW`, 4, width of the pair sequence tag.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  1  word transfer strobe; wired to the buffer's `do_`.
- `in_data`  in  WIDTH  word; wired to the buffer's `d_out`.
- `in_rdy`  out  1  ready for a word; wired to the buffer's `dout_en`.
- `out_vld`  out  1  complete pair held.
- `out_a`  out  WIDTH  first operand of the held pair.
- `out_b`  out  WIDTH  second operand of the held pair.
- `out_tag`  out  TAGW  sequence tag of the held pair.
- `out_rdy`  in  1  FPU issue accepts the pair.
- `flush`  in  1  drop partial operands; present only with `FPU_PAIR_FLUSH_EN`.

## Operation
- One clock domain. Reset is synchronous and active-high.
- `in_vld` is a completed transfer, not a request. The upstream `do_` already includes `dout_en`, so the block must never see `in_vld` while `in_rdy` was low.
- `in_rdy` is combinational from state (and from `flush`) only. It must have no path from `in_vld` or `in_data`, because that would form a loop through the upstream `do_`.
- Storage: pair registers `a_q` and `b_q`, plus staging register `nxt_q`.
- States:
  - S_EMPTY: nothing held. `in_rdy`=1. On `in_vld`: `a_q`<=`in_data`, go to S_HALF.
  - S_HALF: A held. `in_rdy`=1. On `in_vld`: `b_q`<=`in_data`, go to S_PAIR.
  - S_PAIR: pair held, `out_vld`=1, `in_rdy`=1.
    - `out_rdy` and `in_vld`: `a_q`<=`in_data`, go to S_HALF.
    - `out_rdy` only: go to S_EMPTY.
    - `in_vld` only: `nxt_q`<=`in_data`, go to S_PAIR_A.
  - S_PAIR_A: pair held plus staged next A. `out_vld`=1, `in_rdy`=0. On `out_rdy`: `a_q`<=`nxt_q`, go to S_HALF.
- `out_a`=`a_q`, `out_b`=`b_q`, `out_vld`=(state is S_PAIR or S_PAIR_A).
- Tag: `tag_q` increments modulo 2^TAGW on each `out_vld && out_rdy`. `out_tag`=`tag_q`. 2^TAGW-1 wraps to 0.
- `out_a`/`out_b` hold their values while `out_vld` is high and `out_rdy` is low. No data changes under a stalled valid.
- `out_rdy` while `out_vld`=0 is ignored.
- Word order is preserved. Pair k is always words 2k and 2k+1 since reset or since the last flush.

## Timing
- Reset values: state S_EMPTY, `out_vld`=0, `out_a`=`out_b`=0, `out_tag`=0, `nxt_q`=0. `in_rdy`=0 while `rst` is high and 1 in the first cycle after reset.
- Latency: B accepted at edge N gives `out_vld`=1 in the cycle after edge N.
- Full throughput: one word per cycle, one pair every two cycles while `out_rdy` is high. There is no bubble on the S_PAIR -> S_HALF overlap.
- Backpressure: at most one extra word is absorbed after `out_rdy` drops (S_PAIR_A). `in_rdy` then falls the cycle after that word is accepted.
- `rst` mid-operation discards all held words and the tag. The upstream buffer is reset by the same `rst` in the same cycle.

## Configuration
- `FPU_PAIR_FLUSH_EN` defined: the `flush` port exists.
  - While `flush`=1, `in_rdy`=0 and no word is accepted.
  - S_HALF goes to S_EMPTY.
  - S_PAIR_A goes to S_PAIR; `nxt_q` is discarded.
  - A complete held pair is never dropped, and an `out_rdy` handshake in the same cycle still completes. S_PAIR with `out_rdy` goes to S_EMPTY.
  - The tag is not reset.
- Not defined: no `flush` port. Behaviour is identical to `flush` tied to 0.

## Test plan
- Reset, then words 0x11,0x22 on consecutive cycles with `out_rdy`=1 -> `out_vld` for 1 cycle with a=0x11, b=0x22, tag=0.
- Continuous stream 0x1..0x8 with `out_rdy`=1 -> four pairs (1,2),(3,4),(5,6),(7,8), tags 0..3, `in_rdy` never low.
- `out_rdy`=0 with a pair held, then one more word 0x33 -> `in_rdy` low the next cycle, pair unchanged. Raise `out_rdy` -> next pair starts with a=0x33.
- 2^TAGW+1 pairs consumed -> tag sequence ends ...,15,0 for TAGW=4.
- With `FPU_PAIR_FLUSH_EN`: word 0xAA, then `flush` for 1 cycle, then 0xBB,0xCC -> output pair (0xBB,0xCC); 0xAA never appears.
- Assert `rst` in S_PAIR_A -> next cycle `out_vld`=0, tag=0, `in_rdy`=1 after release.
